// File: rtl/video_timing_detector.sv
// video_timing_detector: sink-side video timing analyser.
// Registers an RGB888 stream with active-low hsync/vsync and active-high de,
// measures active/total geometry, locks once the timing repeats and re-emits
// each pixel with its x/y coordinate (2-cycle latency).
// Optional build macro COLOR_CHECK_EN adds a constant-colour pixel checker
// (EXP_R/EXP_G/EXP_B); without it err_count is 0 and color_ok follows locked.
module video_timing_detector #(
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT_W   = 21
`ifdef COLOR_CHECK_EN
  ,
  parameter logic [7:0] EXP_R = 8'd0,
  parameter logic [7:0] EXP_G = 8'd255,
  parameter logic [7:0] EXP_B = 8'd0
`endif
) (
  input  logic        clk_27,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  input  logic [7:0]  rgb_red,
  input  logic [7:0]  rgb_green,
  input  logic [7:0]  rgb_blue,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic [11:0] h_active,
  output logic [11:0] v_active,
  output logic [11:0] h_total,
  output logic [11:0] v_total,
  output logic        locked,
  output logic [15:0] err_count,
  output logic        color_ok
);

  localparam int LCNT_W = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKING, LOCKED} state_t;

  function automatic logic [11:0] sat_inc(input logic [11:0] val);
    return (val == 12'hFFF) ? val : val + 12'd1;
  endfunction

  state_t              state, state_nxt;
  logic [LCNT_W-1:0]   lock_cnt, cnt_nxt;
  logic                store_cand, commit;

  logic                hs_p0, vs_p0, de_p0, hs_p1, vs_p1, de_p1;
  logic [7:0]          red_p0, grn_p0, blu_p0;
  logic                line_ev, frame_ev, de_fall;

  logic [11:0]         hcnt, run_cnt, y_cnt, y_cur;
  logic [11:0]         acc_lines, acc_lev, acc_width, acc_period;
  logic                acc_wset, acc_bad;
  logic [11:0]         lines_n, lev_n, width_n, period_n;
  logic                wset_n, bad_n, consistent, match;
  logic [11:0]         cand_lines, cand_lev, cand_width, cand_period;
  logic                cand_ok;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                wd_max;

  // Stage p0/p1: input sync/de registers and their one-cycle-delayed copies for edge detection
  always_ff @(posedge clk_27 or negedge rst_n) begin
    if (!rst_n) begin
      hs_p0 <= 1'b0; vs_p0 <= 1'b0; de_p0 <= 1'b0;
      hs_p1 <= 1'b0; vs_p1 <= 1'b0; de_p1 <= 1'b0;
    end else begin
      hs_p0 <= hsync; vs_p0 <= vsync; de_p0 <= de;
      hs_p1 <= hs_p0; vs_p1 <= vs_p0; de_p1 <= de_p0;
    end
  end

  // Stage p0: pixel data capture, qualified later by de_p0
  always_ff @(posedge clk_27) begin
    red_p0 <= rgb_red;
    grn_p0 <= rgb_green;
    blu_p0 <= rgb_blue;
  end

  assign line_ev  = hs_p1 & ~hs_p0;
  assign frame_ev = vs_p1 & ~vs_p0;
  assign de_fall  = de_p1 & ~de_p0;
  assign y_cur    = frame_ev ? 12'd0 : y_cnt;
  assign wd_max   = &wd_cnt;

  // Per-frame accumulators including this cycle's events, so a commit sees the complete frame
  always_comb begin
    lines_n  = de_fall ? sat_inc(acc_lines) : acc_lines;
    lev_n    = line_ev ? sat_inc(acc_lev) : acc_lev;
    period_n = line_ev ? sat_inc(hcnt) : acc_period;
    width_n  = acc_width;
    wset_n   = acc_wset;
    bad_n    = acc_bad;
    if (de_fall) begin
      if (!acc_wset) begin
        width_n = run_cnt;
        wset_n  = 1'b1;
      end else if (run_cnt != acc_width) begin
        bad_n = 1'b1;
      end
    end
    if ((&lines_n) || (&lev_n) || (&period_n) || (&width_n)) bad_n = 1'b1;
  end

  assign consistent = ~bad_n;
  assign match = consistent && cand_ok &&
                 (lines_n == cand_lines) && (lev_n == cand_lev) &&
                 (width_n == cand_width) && (period_n == cand_period);

  // Line/run/line-index counters, frame accumulators and the no-vsync watchdog
  always_ff @(posedge clk_27 or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0; run_cnt <= '0; y_cnt <= '0; wd_cnt <= '0;
      acc_lines <= '0; acc_lev <= '0; acc_width <= '0; acc_period <= '0;
      acc_wset <= 1'b0; acc_bad <= 1'b0;
    end else begin
      hcnt <= line_ev ? 12'd0 : sat_inc(hcnt);
      if (de_p0) run_cnt <= de_p1 ? sat_inc(run_cnt) : 12'd1;
      if (frame_ev)     y_cnt <= 12'd0;
      else if (de_fall) y_cnt <= sat_inc(y_cnt);
      wd_cnt <= frame_ev ? '0 : wd_cnt + 1'b1;
      if (frame_ev) begin
        acc_lines <= '0; acc_lev <= '0; acc_width <= '0; acc_period <= '0;
        acc_wset <= 1'b0; acc_bad <= 1'b0;
      end else begin
        acc_lines <= lines_n; acc_lev <= lev_n; acc_width <= width_n;
        acc_period <= period_n; acc_wset <= wset_n; acc_bad <= bad_n;
      end
    end
  end

  // Lock FSM next state: commits happen on frame events outside SEARCH
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = lock_cnt;
    store_cand = 1'b0;
    commit     = 1'b0;
    if (frame_ev) begin
      case (state)
        SEARCH: state_nxt = MEASURE;
        MEASURE: begin
          commit     = 1'b1;
          store_cand = 1'b1;
          if (consistent) begin
            state_nxt = LOCKING;
            cnt_nxt   = '0;
          end
        end
        LOCKING: begin
          commit = 1'b1;
          if (match) begin
            cnt_nxt = lock_cnt + 1'b1;
            if (cnt_nxt == LCNT_W'(LOCK_FRAMES)) state_nxt = LOCKED;
          end else begin
            store_cand = 1'b1;
            cnt_nxt    = '0;
          end
        end
        LOCKED: begin
          commit = 1'b1;
          if (!match) begin
            state_nxt  = LOCKING;
            store_cand = 1'b1;
            cnt_nxt    = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end else if (wd_max) begin
      state_nxt = SEARCH;
      cnt_nxt   = '0;
    end
  end

  // Lock FSM state, candidate and committed measurements
  always_ff @(posedge clk_27 or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH; lock_cnt <= '0;
      cand_lines <= '0; cand_lev <= '0; cand_width <= '0; cand_period <= '0;
      cand_ok <= 1'b0;
      h_active <= '0; v_active <= '0; h_total <= '0; v_total <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= cnt_nxt;
      if (store_cand) begin
        cand_lines <= lines_n; cand_lev <= lev_n; cand_width <= width_n;
        cand_period <= period_n; cand_ok <= consistent;
      end
      if (commit && consistent) begin
        h_active <= width_n; v_active <= lines_n;
        h_total  <= period_n; v_total <= lev_n;
      end
    end
  end

  assign locked = (state == LOCKED);

  // Stage p1 -> outputs: registered pixel, coordinates and frame-start pulse
  always_ff @(posedge clk_27 or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0; pix_r <= '0; pix_g <= '0; pix_b <= '0;
      pix_x <= '0; pix_y <= '0; frame_start <= 1'b0;
    end else begin
      pix_valid   <= de_p0;
      pix_r       <= de_p0 ? red_p0 : 8'd0;
      pix_g       <= de_p0 ? grn_p0 : 8'd0;
      pix_b       <= de_p0 ? blu_p0 : 8'd0;
      frame_start <= de_p0 & ~de_p1 & (y_cur == 12'd0);
      if (de_p0) begin
        pix_x <= de_p1 ? sat_inc(pix_x) : 12'd0;
        pix_y <= y_cur;
      end
    end
  end

`ifdef COLOR_CHECK_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  logic [15:0] err_acc, err_n;

  assign err_n = (de_p0 && ({red_p0, grn_p0, blu_p0} != {EXP_R, EXP_G, EXP_B})) ?
                 sat_inc16(err_acc) : err_acc;

  // Per-frame colour error counter, latched into err_count at each commit
  always_ff @(posedge clk_27 or negedge rst_n) begin
    if (!rst_n) begin
      err_acc   <= '0;
      err_count <= '0;
    end else begin
      err_acc <= frame_ev ? 16'd0 : err_n;
      if (commit) err_count <= err_n;
    end
  end

  assign color_ok = locked && (err_count == 16'd0);
`else
  assign err_count = 16'd0;
  assign color_ok  = locked;
`endif

endmodule

// File: tb/tb_video_timing_detector.sv
// Testbench for video_timing_detector: a small 20x10 (8x6 active) raster
// drives the detector; a table of per-commit expectations walks through
// lock, timing change and relock, followed by watchdog, reset and (when
// COLOR_CHECK_EN is defined) colour-error sequences.
`timescale 1ns/1ps
module tb_video_timing_detector;

  localparam int TW    = 10;
  localparam int H_ACT = 8;
  localparam int V_ACT = 6;
  localparam int V_TOT = 10;
  localparam int HS_A  = 10;
  localparam int HS_B  = 14;
  localparam int VS_A  = 7;
  localparam int VS_B  = 9;

  logic        clk_27 = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b1, vsync = 1'b1, de = 1'b0;
  logic [7:0]  rgb_red = '0, rgb_green = '0, rgb_blue = '0;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_valid, frame_start, locked, color_ok;
  logic [11:0] pix_x, pix_y, h_active, v_active, h_total, v_total;
  logic [15:0] err_count;

  video_timing_detector #(.LOCK_FRAMES(2), .TIMEOUT_W(TW)) dut (
    .clk_27(clk_27), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .de(de),
    .rgb_red(rgb_red), .rgb_green(rgb_green), .rgb_blue(rgb_blue),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .h_active(h_active), .v_active(v_active), .h_total(h_total), .v_total(v_total),
    .locked(locked), .err_count(err_count), .color_ok(color_ok)
  );

  always #5 clk_27 = ~clk_27;

  typedef struct {
    int h_tot;
    bit pre;
    bit lk;
    int ha, va, ht, vt;
  } vec_t;

  vec_t tbl [8];

  int checks = 0;
  int failures = 0;
  int h = 0, v = 0, h_tot = 20;
  bit no_vs = 1'b0, pix_chk = 1'b0, inject = 1'b0;
  bit vs_prev = 1'b1, vs_fell = 1'b0;
  bit d1_de = 1'b0, d2_de = 1'b0;
  int d1_h = 0, d1_v = 0, d2_h = 0, d2_v = 0;
  logic [23:0] d1_rgb = '0, d2_rgb = '0;
  int ex = 0, ey = 0, fs_seen = 0, last_x = 0, last_y = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: observe outputs at negedge against the 2-cycle-old stimulus, then drive
  task automatic tick();
    logic [23:0] px;
    @(negedge clk_27);
    if (d2_de) begin ex = d2_h; ey = d2_v; end
    if (pix_chk) begin
      check("pix_valid", int'(pix_valid), int'(d2_de));
      check("pix_rgb", int'({pix_r, pix_g, pix_b}), int'(d2_de ? d2_rgb : 24'd0));
      check("pix_x", int'(pix_x), ex);
      check("pix_y", int'(pix_y), ey);
      check("frame_start", int'(frame_start), int'(d2_de && d2_h == 0 && d2_v == 0));
      if (frame_start) fs_seen++;
      if (pix_valid) begin last_x = int'(pix_x); last_y = int'(pix_y); end
    end
    d2_de = d1_de; d2_h = d1_h; d2_v = d1_v; d2_rgb = d1_rgb;
    hsync = !(h >= HS_A && h < HS_B);
    vsync = no_vs || !(v >= VS_A && v < VS_B);
    de    = (h < H_ACT) && (v < V_ACT);
    px    = (inject && v == 3 && h >= 1 && h <= 5) ? 24'hFF0000 : 24'h00FF00;
    if (!de) px = 24'd0;
    {rgb_red, rgb_green, rgb_blue} = px;
    vs_fell = vs_prev && !vsync;
    vs_prev = vsync;
    d1_de = de; d1_h = h; d1_v = v; d1_rgb = px;
    h++;
    if (h >= h_tot) begin
      h = 0;
      v = (v + 1) % V_TOT;
    end
  endtask

  // Run up to the next vsync fall; check locked just before and leave time at the commit
  task automatic run_commit(input string tag, input bit pre_exp);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!vs_fell && n < 5000);
    if (!vs_fell) begin
      checks++;
      failures++;
      $display("FAIL %s_vsync_wait: waited %0d cycles, required a vsync fall", tag, n);
    end
    tick();
    check({tag, "_pre_locked"}, int'(locked), int'(pre_exp));
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_valid"}, int'(pix_valid), 0);
    check({tag, "_pix_rgb"}, int'({pix_r, pix_g, pix_b}), 0);
    check({tag, "_pix_xy"}, int'({pix_x, pix_y}), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_active"}, int'({h_active, v_active}), 0);
    check({tag, "_total"}, int'({h_total, v_total}), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
    check({tag, "_color_ok"}, int'(color_ok), 0);
  endtask

  task automatic apply_vec(input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    h_tot = tbl[i].h_tot;
    run_commit(tag, tbl[i].pre);
    check({tag, "_locked"}, int'(locked), int'(tbl[i].lk));
    check({tag, "_h_active"}, int'(h_active), tbl[i].ha);
    check({tag, "_v_active"}, int'(v_active), tbl[i].va);
    check({tag, "_h_total"}, int'(h_total), tbl[i].ht);
    check({tag, "_v_total"}, int'(v_total), tbl[i].vt);
    check({tag, "_err_count"}, int'(err_count), 0);
    check({tag, "_color_ok"}, int'(color_ok), int'(tbl[i].lk));
  endtask

  initial begin
    int n;
    // h_tot, locked before commit, locked after, h_active, v_active, h_total, v_total
    tbl[0] = '{20, 1'b0, 1'b0, 0, 0,  0,  0};   // first fall: SEARCH, nothing committed
    tbl[1] = '{20, 1'b0, 1'b0, 8, 6, 20, 10};   // candidate stored, LOCKING
    tbl[2] = '{20, 1'b0, 1'b0, 8, 6, 20, 10};   // match 1
    tbl[3] = '{20, 1'b0, 1'b1, 8, 6, 20, 10};   // match 2 -> locked at 4th fall
    tbl[4] = '{20, 1'b1, 1'b1, 8, 6, 20, 10};   // stays locked
    tbl[5] = '{18, 1'b1, 1'b0, 8, 6, 18, 10};   // h_total change drops lock at this commit
    tbl[6] = '{18, 1'b0, 1'b0, 8, 6, 18, 10};
    tbl[7] = '{18, 1'b0, 1'b1, 8, 6, 18, 10};   // relocked two frames later

    repeat (3) @(negedge clk_27);
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        pix_chk = 1'b1;
        fs_seen = 0;
      end
      apply_vec(i);
      if (i == 4) begin
        pix_chk = 1'b0;
        check("frame_start_count", fs_seen, 1);
        check("last_pix_x", last_x, H_ACT - 1);
        check("last_pix_y", last_y, V_ACT - 1);
      end
    end

    // Watchdog: commit landed 2 ticks after the last vsync fall; timeout 2^TW edges after commit
    no_vs = 1'b1;
    repeat ((1 << TW) - 1) tick();
    check("wd_locked_before", int'(locked), 1);
    tick();
    check("wd_locked_after", int'(locked), 0);
    check("wd_h_total_held", int'(h_total), 18);
    check("wd_h_active_held", int'(h_active), 8);
    check("wd_v_held", int'({v_active, v_total}), int'({12'd6, 12'd10}));

    // Asynchronous reset in the middle of an active line
    no_vs = 1'b0;
    h_tot = 20;
    n = 0;
    while (!(v == 2 && h == 4) && n < 1000) begin
      tick();
      n++;
    end
    tick();
    check("pre_reset_pix_valid", int'(pix_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midline_reset");
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply_vec(i);

`ifdef COLOR_CHECK_EN
    inject = 1'b1;
    run_commit("red", 1'b1);
    inject = 1'b0;
    check("red_err_count", int'(err_count), 5);
    check("red_color_ok", int'(color_ok), 0);
    check("red_locked", int'(locked), 1);
    run_commit("clean", 1'b1);
    check("clean_err_count", int'(err_count), 0);
    check("clean_color_ok", int'(color_ok), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation reached %0t, required completion earlier", $time);
    $fatal(1, "time limit");
  end

endmodule
